// File: rtl/phaser_in_tap_ctrl_if.sv
// ============================================================================
// Module  : phaser_in_tap_ctrl_if
// Brief   : Host request/response bundle for the PHASER_IN tap sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface phaser_in_tap_ctrl_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic [5:0] REQ_DATA;
    logic       RSP_VALID;
    logic [5:0] RSP_DATA;
    logic       RSP_ERR;

    modport master (
        output REQ_VALID, REQ_OP, REQ_DATA,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_DATA,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
    );
endinterface

`default_nettype wire

// File: rtl/phaser_in_tap_ctrl.sv
// ============================================================================
// Module  : phaser_in_tap_ctrl
// Brief   : Sequences host LOAD/READ/STEP/SET requests into PHASER_IN pulses,
//           tracks the fine-tap position. Optional ERR_CNT via
//           PHASER_IN_TAP_CTRL_STATS_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module phaser_in_tap_ctrl #(
    parameter int unsigned STEP_GAP  = 8,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned FINE_INIT = 0
) (
    input  wire logic             SYSCLK,
    input  wire logic             RST_N,
    phaser_in_tap_ctrl_if.slave   host,
    output logic [5:0]            FINE_POS,
    output logic                  COUNTERLOADEN,
    output logic [5:0]            COUNTERLOADVAL,
    output logic                  COUNTERREADEN,
    input  wire logic [5:0]       COUNTERREADVAL,
    output logic                  FINEENABLE,
    output logic                  FINEINC,
    input  wire logic             FINEOVERFLOW
`ifdef PHASER_IN_TAP_CTRL_STATS_EN
    ,
    output logic [7:0]            ERR_CNT
`endif
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_RD_PULSE   = 3'd2;
    localparam logic [2:0] S_RD_WAIT    = 3'd3;
    localparam logic [2:0] S_STEP_PULSE = 3'd4;
    localparam logic [2:0] S_STEP_GAP   = 3'd5;
    localparam logic [2:0] S_RESP       = 3'd6;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b11;

    localparam logic [7:0] GAP_RELOAD = 8'(STEP_GAP - 1);
    localparam logic [7:0] RD_RELOAD  = 8'(READ_LAT - 1);

    logic [2:0] state_q, state_d;
    logic       dir_q;
    logic [5:0] taps_q;
    logic [7:0] cnt_q;
    logic       ovf_q;
    logic [5:0] fine_pos_q;
    logic [5:0] loadval_q;
    logic [5:0] rsp_data_q;
    logic       rsp_err_q;

    logic       w_accept;
    logic       w_req_dir;
    logic [5:0] w_req_taps;
    logic       w_req_blocked;
    logic       w_cur_blocked;
    logic       w_fin_err;
    logic [5:0] w_rsp_data;

    assign w_accept = host.REQ_VALID && (state_q == S_IDLE);

    // SET is turned into an equivalent relative move from the current position
    always_comb begin
        w_req_dir  = host.REQ_DATA[5];
        w_req_taps = {1'b0, host.REQ_DATA[4:0]};
        if (host.REQ_OP == OP_SET) begin
            w_req_dir  = host.REQ_DATA > fine_pos_q;
            w_req_taps = w_req_dir ? (host.REQ_DATA - fine_pos_q)
                                   : (fine_pos_q - host.REQ_DATA);
        end
    end

    assign w_req_blocked = w_req_dir ? (fine_pos_q == 6'd63) : (fine_pos_q == 6'd0);
    assign w_cur_blocked = dir_q     ? (fine_pos_q == 6'd63) : (fine_pos_q == 6'd0);

    assign w_rsp_data = (state_q == S_LOAD)    ? loadval_q      :
                        (state_q == S_RD_WAIT) ? COUNTERREADVAL : fine_pos_q;

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_fin_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (host.REQ_OP == OP_LOAD) begin
                        state_d = S_LOAD;
                    end else if (host.REQ_OP == OP_READ) begin
                        state_d = S_RD_PULSE;
                    end else if (w_req_taps == 6'd0) begin
                        state_d = S_RESP;
                    end else if (w_req_blocked) begin
                        state_d   = S_RESP;
                        w_fin_err = 1'b1;
                    end else begin
                        state_d = S_STEP_PULSE;
                    end
                end
            end
            S_LOAD:       state_d = S_RESP;
            S_RD_PULSE:   state_d = S_RD_WAIT;
            S_RD_WAIT:    if (cnt_q == 8'd0) state_d = S_RESP;
            S_STEP_PULSE: state_d = S_STEP_GAP;
            S_STEP_GAP: begin
                if (cnt_q == 8'd0) begin
                    if (ovf_q || FINEOVERFLOW) begin
                        state_d   = S_RESP;
                        w_fin_err = 1'b1;
                    end else if (taps_q == 6'd0) begin
                        state_d = S_RESP;
                    end else if (w_cur_blocked) begin
                        state_d   = S_RESP;
                        w_fin_err = 1'b1;
                    end else begin
                        state_d = S_STEP_PULSE;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        host.REQ_READY = (state_q == S_IDLE);
        host.RSP_VALID = (state_q == S_RESP);
        host.RSP_DATA  = rsp_data_q;
        host.RSP_ERR   = rsp_err_q;
        COUNTERLOADEN  = (state_q == S_LOAD);
        COUNTERLOADVAL = loadval_q;
        COUNTERREADEN  = (state_q == S_RD_PULSE);
        FINEENABLE     = (state_q == S_STEP_PULSE);
        FINEINC        = (state_q == S_STEP_PULSE) && dir_q;
        FINE_POS       = fine_pos_q;
    end

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            dir_q      <= 1'b0;
            taps_q     <= 6'd0;
            cnt_q      <= 8'd0;
            ovf_q      <= 1'b0;
            fine_pos_q <= 6'(FINE_INIT);
            loadval_q  <= 6'd0;
            rsp_data_q <= 6'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        dir_q     <= w_req_dir;
                        taps_q    <= w_req_taps;
                        ovf_q     <= 1'b0;
                        rsp_err_q <= 1'b0;
                        if (host.REQ_OP == OP_LOAD) loadval_q <= host.REQ_DATA;
                    end
                end
                S_RD_PULSE: cnt_q <= RD_RELOAD;
                S_RD_WAIT:  cnt_q <= cnt_q - 8'd1;
                S_STEP_PULSE: begin
                    fine_pos_q <= dir_q ? (fine_pos_q + 6'd1) : (fine_pos_q - 6'd1);
                    taps_q     <= taps_q - 6'd1;
                    cnt_q      <= GAP_RELOAD;
                end
                S_STEP_GAP: begin
                    cnt_q <= cnt_q - 8'd1;
                    ovf_q <= ovf_q | FINEOVERFLOW;
                end
                default: ;
            endcase
            // Response payload is latched on the way into RESP and held afterwards
            if (state_d == S_RESP) begin
                rsp_data_q <= w_rsp_data;
                rsp_err_q  <= w_fin_err;
            end
        end
    end

`ifdef PHASER_IN_TAP_CTRL_STATS_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt_q <= 8'd0;
        end else if ((state_q == S_RESP) && rsp_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phaser_in_tap_ctrl.sv
// ============================================================================
// Module  : tb_phaser_in_tap_ctrl
// Brief   : Directed + randomized bench for phaser_in_tap_ctrl with an
//           arithmetic reference model of tap position, timing and errors.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phaser_in_tap_ctrl;
    localparam int GAP  = 8;
    localparam int RL   = 2;
    localparam int FINI = 0;

    logic       SYSCLK = 1'b0;
    logic       RST_N  = 1'b0;
    logic [5:0] FINE_POS;
    logic       COUNTERLOADEN;
    logic [5:0] COUNTERLOADVAL;
    logic       COUNTERREADEN;
    logic [5:0] COUNTERREADVAL = 6'd0;
    logic       FINEENABLE;
    logic       FINEINC;
    logic       FINEOVERFLOW = 1'b0;
`ifdef PHASER_IN_TAP_CTRL_STATS_EN
    logic [7:0] ERR_CNT;
`endif

    phaser_in_tap_ctrl_if bus ();

    phaser_in_tap_ctrl #(.STEP_GAP(GAP), .READ_LAT(RL), .FINE_INIT(FINI)) dut (
        .SYSCLK         (SYSCLK),
        .RST_N          (RST_N),
        .host           (bus),
        .FINE_POS       (FINE_POS),
        .COUNTERLOADEN  (COUNTERLOADEN),
        .COUNTERLOADVAL (COUNTERLOADVAL),
        .COUNTERREADEN  (COUNTERREADEN),
        .COUNTERREADVAL (COUNTERREADVAL),
        .FINEENABLE     (FINEENABLE),
        .FINEINC        (FINEINC),
        .FINEOVERFLOW   (FINEOVERFLOW)
`ifdef PHASER_IN_TAP_CTRL_STATS_EN
        ,
        .ERR_CNT        (ERR_CNT)
`endif
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses_total = 0;
    int inc_total = 0;
    int bad_inc = 0;
    int rsp_total = 0;
    int ovf_arm = 0;
    int load_cyc = -1;
    int read_cyc = -1;
    logic [5:0] load_val = 6'd0;
    int pulse_cyc [1024];
    logic [5:0] rv_hist [1024];

    int m_pos = FINI;
    int m_errs = 0;
    int m_ops = 0;
    logic [5:0] m_loadval = 6'd0;

    always @(posedge SYSCLK) cyc <= cyc + 1;

    // PHASER_IN stand-in: records pulses, serves random counter values, injects overflow
    always @(negedge SYSCLK) begin
        if (FINEENABLE) begin
            pulse_cyc[pulses_total % 1024] = cyc;
            if (FINEINC) inc_total++;
            pulses_total++;
        end
        if (!FINEENABLE && FINEINC) bad_inc++;
        if (COUNTERLOADEN) begin
            load_cyc = cyc;
            load_val = COUNTERLOADVAL;
        end
        if (COUNTERREADEN) read_cyc = cyc;
        if (bus.RSP_VALID) rsp_total++;
        COUNTERREADVAL = 6'($urandom);
        rv_hist[cyc % 1024] = COUNTERREADVAL;
        FINEOVERFLOW = (ovf_arm != 0) && (pulses_total >= ovf_arm);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [5:0] data, input int ovf_at);
        int a, base, ibase, n, lim, taps, exp_rsp, rc, got, t;
        logic dir, exp_err, got_rsp, re;
        logic [5:0] exp_data, rd;
        t = 0;
        while (!bus.REQ_READY && t < 50) begin
            @(negedge SYSCLK);
            t++;
        end
        base  = pulses_total;
        ibase = inc_total;
        ovf_arm = (ovf_at > 0) ? base + ovf_at : 0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP    = op;
        bus.REQ_DATA  = data;
        a = cyc;
        taps = 0;
        dir = 1'b0;
        exp_err = 1'b0;
        exp_data = data;
        exp_rsp = a + 2;
        if (op == 2'b01) exp_rsp = a + 2 + RL;
        if (op[1]) begin
            if (op == 2'b10) begin
                dir = data[5];
                n = int'(data[4:0]);
            end else begin
                dir = int'(data) > m_pos;
                n = dir ? int'(data) - m_pos : m_pos - int'(data);
            end
            lim = dir ? 63 - m_pos : m_pos;
            taps = (n < lim) ? n : lim;
            exp_err = n > lim;
            if (ovf_at > 0 && ovf_at <= taps) begin
                taps = ovf_at;
                exp_err = 1'b1;
            end
            exp_rsp = a + 1 + taps * (GAP + 1);
            m_pos = dir ? m_pos + taps : m_pos - taps;
            exp_data = 6'(m_pos);
        end
        if (op == 2'b00) m_loadval = data;
        @(negedge SYSCLK);
        bus.REQ_VALID = 1'b0;
        got_rsp = 1'b0;
        rc = -1;
        rd = 6'd0;
        re = 1'b0;
        for (int i = 0; i < 3000 && !got_rsp; i++) begin
            if (bus.RSP_VALID) begin
                got_rsp = 1'b1;
                rc = cyc;
                rd = bus.RSP_DATA;
                re = bus.RSP_ERR;
            end else begin
                @(negedge SYSCLK);
            end
        end
        ovf_arm = 0;
        m_ops++;
        if (exp_err && m_errs < 255) m_errs++;
        if (op == 2'b01) exp_data = rv_hist[(a + 1 + RL) % 1024];
        chk("rsp_seen", 32'(got_rsp), 32'd1);
        chk("rsp_latency", 32'(rc - a), 32'(exp_rsp - a));
        chk("rsp_data", 32'(rd), 32'(exp_data));
        chk("rsp_err", 32'(re), 32'(exp_err));
        @(negedge SYSCLK);
        chk("rsp_one_cycle", 32'(bus.RSP_VALID), 32'd0);
        chk("rsp_hold", 32'(bus.RSP_DATA), 32'(exp_data));
        chk("fine_pos", 32'(FINE_POS), 32'(m_pos));
        chk("loadval_hold", 32'(COUNTERLOADVAL), 32'(m_loadval));
        if (op == 2'b00) begin
            chk("load_cycle", 32'(load_cyc - a), 32'd1);
            chk("load_val", 32'(load_val), 32'(data));
        end else if (op == 2'b01) begin
            chk("read_cycle", 32'(read_cyc - a), 32'd1);
        end else begin
            got = pulses_total - base;
            chk("pulse_count", 32'(got), 32'(taps));
            chk("inc_count", 32'(inc_total - ibase), dir ? 32'(got) : 32'd0);
            if (taps > 0 && got == taps) begin
                chk("first_pulse", 32'(pulse_cyc[base % 1024] - a), 32'd1);
                chk("last_pulse", 32'(pulse_cyc[(base + taps - 1) % 1024] - a),
                    32'(1 + (taps - 1) * (GAP + 1)));
            end
        end
`ifdef PHASER_IN_TAP_CTRL_STATS_EN
        chk("err_cnt", 32'(ERR_CNT), 32'(m_errs));
`endif
    endtask

    initial begin
        int a0, rsp_base, ovf;
        logic [1:0] rop;
        bus.REQ_VALID = 1'b0;
        bus.REQ_OP    = 2'b00;
        bus.REQ_DATA  = 6'd0;
        repeat (3) @(negedge SYSCLK);
        chk("rst_ready", 32'(bus.REQ_READY), 32'd1);
        chk("rst_fine_pos", 32'(FINE_POS), 32'(FINI));
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("rst_outputs", {26'd0, COUNTERLOADEN, COUNTERREADEN, FINEENABLE, FINEINC,
                            bus.RSP_ERR, 1'b0}, 32'd0);
        RST_N = 1'b1;
        @(negedge SYSCLK);

        run_op(2'b00, 6'h2A, 0);
        run_op(2'b01, 6'h00, 0);
        run_op(2'b10, 6'h23, 0);
        run_op(2'b11, 6'd62, 0);
        run_op(2'b11, 6'd60, 0);
        run_op(2'b10, 6'h25, 0);
        run_op(2'b11, 6'd20, 0);
        run_op(2'b10, 6'h2A, 2);
        run_op(2'b10, 6'h20, 0);
        run_op(2'b11, 6'd22, 0);
        run_op(2'b11, 6'd0, 0);
        run_op(2'b10, 6'h01, 0);

        // Reset in the gap after the first tap of a 5-tap increment
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP    = 2'b10;
        bus.REQ_DATA  = 6'h25;
        a0 = cyc;
        @(negedge SYSCLK);
        bus.REQ_VALID = 1'b0;
        repeat (3) @(negedge SYSCLK);
        chk("pre_rst_pos", 32'(FINE_POS), 32'(m_pos + 1));
        rsp_base = rsp_total;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.REQ_READY), 32'd1);
        chk("mid_rst_pos", 32'(FINE_POS), 32'(FINI));
        chk("mid_rst_loadval", 32'(COUNTERLOADVAL), 32'd0);
        chk("mid_rst_rsp", {bus.RSP_VALID, bus.RSP_ERR, FINEENABLE, FINEINC, bus.RSP_DATA}, 32'd0);
        @(negedge SYSCLK);
        RST_N = 1'b1;
        m_pos = FINI;
        m_errs = 0;
        m_loadval = 6'd0;
        repeat (20) @(negedge SYSCLK);
        chk("abort_no_rsp", 32'(rsp_total - rsp_base), 32'd0);
        chk("post_rst_ready", 32'(bus.REQ_READY), 32'd1);
        chk("post_rst_pos", 32'(FINE_POS), 32'(FINI));
        chk("abort_cycle_used", 32'(cyc > a0), 32'd1);
        rsp_base = rsp_total;
        m_ops = 0;

        for (int k = 0; k < 20; k++) begin
            rop = 2'($urandom_range(0, 3));
            ovf = (rop[1] && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_op(rop, 6'($urandom), ovf);
        end

        chk("rsp_total", 32'(rsp_total - rsp_base), 32'(m_ops));
        chk("fineinc_idle", 32'(bad_inc), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
